// File: rtl/tile_redraw_ctrl.sv
// Tile redraw controller: tracks per-tile status changes against a snapshot
// and scans dirty tiles pixel by pixel in round-robin order.
module tile_redraw_ctrl #(
    parameter int TILE_W = 19,
    parameter int TILE_H = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] mineMap,
    input  logic [63:0] flagMap,
    input  logic [63:0] stepMap,
    input  logic [63:0] posMap,
    input  logic        full_redraw,
    output logic [5:0]  tile_n,
    output logic [4:0]  x_count,
    output logic [3:0]  y_count,
    output logic        plot,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [4:0] X_LAST = 5'(TILE_W - 1);
    localparam logic [3:0] Y_LAST = 4'(TILE_H - 1);

    typedef enum logic [1:0] {IDLE, SELECT, DRAW} state_t;

    state_t      state;
    logic [3:0]  snap [64];
    logic [63:0] dirty;
    logic [63:0] dirty_nxt;
    logic [63:0] diff;
    logic [63:0] clr;
    logic [63:0] rot;
    logic [5:0]  ptr;
    logic [5:0]  off;
    logic [5:0]  sel;

    // Round-robin pick: lowest dirty index at or above ptr, wrapping past 63
    always_comb begin
        rot = 64'({dirty, dirty} >> ptr);
        off = '0;
        for (int k = 63; k >= 0; k--) begin
            if (rot[k]) off = 6'(k);
        end
        sel = ptr + off;
    end

    // Next dirty vector; the tile being selected compares against its new snapshot
    always_comb begin
        diff = '0;
        for (int i = 0; i < 64; i++) begin
            diff[i] = ({posMap[i], mineMap[i], flagMap[i], stepMap[i]} != snap[i]);
        end
        clr = '0;
        if (state == SELECT) begin
            diff[sel] = 1'b0;
            clr[sel]  = 1'b1;
        end
        dirty_nxt = (dirty & ~clr) | diff | {64{full_redraw}};
    end

    // Dirty bits: sets take priority over the SELECT clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dirty <= '1;
        else       dirty <= dirty_nxt;
    end

    // Snapshot of each tile's status as of its last SELECT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) snap[i] <= '0;
        end else if (state == SELECT) begin
            snap[sel] <= {posMap[sel], mineMap[sel], flagMap[sel], stepMap[sel]};
        end
    end

    // Control FSM with registered scan outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            tile_n     <= '0;
            x_count    <= '0;
            y_count    <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|dirty) begin
                        state <= SELECT;
                        busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    tile_n  <= sel;
                    x_count <= '0;
                    y_count <= '0;
                    plot    <= 1'b1;
                    state   <= DRAW;
                end
                DRAW: begin
                    if (x_count == X_LAST) begin
                        x_count <= '0;
                        if (y_count == Y_LAST) begin
                            y_count    <= '0;
                            state      <= IDLE;
                            plot       <= 1'b0;
                            busy       <= 1'b0;
                            ptr        <= tile_n + 6'd1;
                            frame_done <= (dirty_nxt == '0);
                        end else begin
                            y_count <= y_count + 4'd1;
                        end
                    end else begin
                        x_count <= x_count + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_redraw_ctrl.sv
// Directed testbench for tile_redraw_ctrl: draw order, scan order,
// frame_done timing, set-wins priority and mid-draw reset.
module tb_tile_redraw_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] mineMap, flagMap, stepMap, posMap;
    logic        full_redraw;
    logic [5:0]  tile_n;
    logic [4:0]  x_count;
    logic [3:0]  y_count;
    logic        plot, busy, frame_done;

    int nerr = 0;
    int nchk = 0;

    int plots = 0;
    int fd_count = 0;
    int scan_bad = 0;
    int ex = 0;
    int ey = 0;
    int seq[$];

    tile_redraw_ctrl dut (
        .clk(clk),
        .reset(reset),
        .mineMap(mineMap),
        .flagMap(flagMap),
        .stepMap(stepMap),
        .posMap(posMap),
        .full_redraw(full_redraw),
        .tile_n(tile_n),
        .x_count(x_count),
        .y_count(y_count),
        .plot(plot),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Observe plot cycles: draw sequence, pixel count, raster order
    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (plot) begin
            plots++;
            if (!busy) scan_bad++;
            if (x_count == 0 && y_count == 0) seq.push_back(int'(tile_n));
            if (int'(x_count) != ex || int'(y_count) != ey) scan_bad++;
            if (ex == 18) begin
                ex = 0;
                ey = (ey == 13) ? 0 : ey + 1;
            end else begin
                ex++;
            end
        end else begin
            ex = 0;
            ey = 0;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(input int bound, output int cycles);
        cycles = 0;
        while (frame_done !== 1'b1 && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic clear_obs();
        seq.delete();
        plots = 0;
        fd_count = 0;
        scan_bad = 0;
    endtask

    initial begin
        int cyc;
        int ok;
        reset = 1'b1;
        mineMap = '0;
        flagMap = '0;
        stepMap = '0;
        posMap = '0;
        full_redraw = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_tile", tile_n, 0);
        chk("rst_x", x_count, 0);
        chk("rst_y", y_count, 0);

        // Full board draw after reset release
        clear_obs();
        reset = 1'b0;
        wait_fd(20000, cyc);
        chk("boot_fd_seen", frame_done, 1);
        chk("boot_cycles", cyc, 64 * 268);
        repeat (3) @(negedge clk);
        chk("boot_plots", plots, 17024);
        chk("boot_ntiles", seq.size(), 64);
        ok = (seq.size() == 64);
        for (int k = 0; k < seq.size(); k++) if (seq[k] != k) ok = 0;
        chk("boot_order", ok, 1);
        chk("boot_fd_once", fd_count, 1);
        chk("boot_scan", scan_bad, 0);

        // Single tile change
        clear_obs();
        flagMap[9] = 1'b1;
        wait_fd(2000, cyc);
        chk("one_fd_seen", frame_done, 1);
        repeat (3) @(negedge clk);
        chk("one_ntiles", seq.size(), 1);
        chk("one_tile", (seq.size() > 0) ? seq[0] : -1, 9);
        chk("one_plots", plots, 266);
        chk("one_scan", scan_bad, 0);
        chk("one_fd_once", fd_count, 1);
        chk("idle_tile_hold", tile_n, 9);
        chk("idle_x", x_count, 0);
        chk("idle_y", y_count, 0);
        chk("idle_busy", busy, 0);

        // Move pointer to 60, then wraparound ordering
        clear_obs();
        flagMap[59] = 1'b1;
        wait_fd(2000, cyc);
        repeat (3) @(negedge clk);
        chk("t59_tile", (seq.size() > 0) ? seq[0] : -1, 59);
        clear_obs();
        stepMap[3] = 1'b1;
        stepMap[62] = 1'b1;
        wait_fd(2000, cyc);
        chk("wrap_fd_seen", frame_done, 1);
        repeat (3) @(negedge clk);
        chk("wrap_ntiles", seq.size(), 2);
        chk("wrap_first", (seq.size() > 0) ? seq[0] : -1, 62);
        chk("wrap_second", (seq.size() > 1) ? seq[1] : -1, 3);
        chk("wrap_plots", plots, 532);
        chk("wrap_fd_once", fd_count, 1);

        // Status change on the tile being drawn
        clear_obs();
        posMap[20] = 1'b1;
        cyc = 0;
        while (!(plot === 1'b1 && tile_n == 6'd20) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("redraw_started", plot, 1);
        repeat (50) @(negedge clk);
        posMap[20] = 1'b0;
        wait_fd(2000, cyc);
        chk("redraw_fd_seen", frame_done, 1);
        repeat (3) @(negedge clk);
        chk("redraw_ntiles", seq.size(), 2);
        chk("redraw_a", (seq.size() > 0) ? seq[0] : -1, 20);
        chk("redraw_b", (seq.size() > 1) ? seq[1] : -1, 20);
        chk("redraw_fd_once", fd_count, 1);

        // full_redraw during SELECT of tile 5: set beats clear
        clear_obs();
        mineMap[5] = 1'b1;
        cyc = 0;
        while (busy !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("sel_busy", busy, 1);
        chk("sel_noplot", plot, 0);
        full_redraw = 1'b1;
        @(negedge clk);
        full_redraw = 1'b0;
        wait_fd(20000, cyc);
        chk("setwin_fd_seen", frame_done, 1);
        repeat (3) @(negedge clk);
        chk("setwin_ntiles", seq.size(), 65);
        ok = (seq.size() == 65);
        for (int k = 0; k < seq.size() && k < 64; k++) if (seq[k] != (5 + k) % 64) ok = 0;
        if (seq.size() == 65 && seq[64] != 5) ok = 0;
        chk("setwin_order", ok, 1);
        chk("setwin_fd_once", fd_count, 1);

        // Reset asserted on the 100th draw cycle of tile 7
        clear_obs();
        flagMap[7] = 1'b1;
        cyc = 0;
        while (!(plot === 1'b1 && tile_n == 6'd7) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("t7_started", plot, 1);
        repeat (99) @(negedge clk);
        chk("t7_x_at100", x_count, 99 % 19);
        chk("t7_y_at100", y_count, 99 / 19);
        reset = 1'b1;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tile", tile_n, 0);
        chk("abort_x", x_count, 0);
        @(negedge clk);
        chk("abort_plot_held", plot, 0);
        clear_obs();
        reset = 1'b0;
        wait_fd(20000, cyc);
        chk("rerun_fd_seen", frame_done, 1);
        chk("rerun_cycles", cyc, 64 * 268);
        repeat (3) @(negedge clk);
        chk("rerun_ntiles", seq.size(), 64);
        ok = (seq.size() == 64);
        for (int k = 0; k < seq.size(); k++) if (seq[k] != k) ok = 0;
        chk("rerun_order", ok, 1);
        chk("rerun_plots", plots, 17024);
        chk("rerun_scan", scan_bad, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/tile_redraw_ctrl.md
TILE_REDRAW_CTRL -- requirements
Module: tile_redraw_ctrl

Interface
REQ-001 Parameter TILE_W, default 19, tile width in pixels (x_count range 0..TILE_W-1).
REQ-002 Parameter TILE_H, default 14, tile height in pixels (y_count range 0..TILE_H-1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mineMap, flagMap, stepMap, posMap  input  64 each  per-tile board state; bit i belongs to tile i.
REQ-006 full_redraw  input  1  single-cycle request to mark all 64 tiles dirty.
REQ-007 tile_n  output  6  tile currently being drawn.
REQ-008 x_count  output  5  pixel column within the tile.
REQ-009 y_count  output  4  pixel row within the tile.
REQ-010 plot  output  1  high exactly on cycles where tile_n/x_count/y_count name a pixel to write.
REQ-011 busy  output  1  high while a tile is being selected or drawn.
REQ-012 frame_done  output  1  one-cycle pulse when the last dirty tile completes.

Function
REQ-013 Status of tile i SHALL be {posMap[i], mineMap[i], flagMap[i], stepMap[i]}; the block SHALL hold a 64x4 snapshot of the last drawn status and a 64-bit dirty vector.
REQ-014 Every cycle, dirty[i] SHALL be set when current status of tile i differs from snapshot[i]; setting takes effect the following cycle.
REQ-015 full_redraw high SHALL set all 64 dirty bits on the next edge, in any state.
REQ-016 FSM states: IDLE, SELECT, DRAW.
REQ-017 IDLE -> SELECT when any dirty bit is set; otherwise remain in IDLE.
REQ-018 SELECT (1 cycle): choose the lowest-index dirty tile at or above the round-robin pointer, wrapping 63 -> 0; latch it into tile_n; copy its current status into snapshot; clear its dirty bit; x_count = y_count = 0; -> DRAW.
REQ-019 If a dirty-set condition (REQ-014/REQ-015) and the SELECT clear hit the same bit in the same cycle, set SHALL win.
REQ-020 DRAW: plot = 1 every cycle; x_count increments 0..TILE_W-1, then wraps to 0 while y_count increments; DRAW lasts exactly TILE_W*TILE_H cycles (266 by default).
REQ-021 At x_count = TILE_W-1 and y_count = TILE_H-1: -> IDLE; pointer = tile_n+1 mod 64; x_count/y_count return to 0.
REQ-022 frame_done SHALL pulse on the cycle after the final DRAW cycle when no dirty bit is set at that time.
REQ-023 A status change on the tile being drawn SHALL re-dirty it (snapshot holds the SELECT-time value), so it is redrawn later.
REQ-024 plot SHALL be 0 in IDLE and SELECT; busy SHALL be 1 in SELECT and DRAW.
REQ-025 tile_n, x_count and y_count SHALL hold their values while in IDLE.
REQ-026 Per-tile cost SHALL be 268 cycles (IDLE 1 + SELECT 1 + DRAW 266) when tiles are drawn back-to-back.

Reset
REQ-027 On reset: state IDLE, snapshot all 0, dirty all 1, pointer 0, tile_n 0, x_count 0, y_count 0, plot 0, busy 0, frame_done 0.
REQ-028 Reset asserted mid-DRAW SHALL abort immediately, with no further plot cycles, and apply REQ-027.

Verification
REQ-029 Release reset with all maps 0 -> tiles 0..63 drawn in ascending order, 266 plot cycles each, 64*266 = 17024 plot cycles total; frame_done pulses once, 64*268 cycles after reset release.
REQ-030 Idle board, set flagMap[9] -> exactly one tile (9) drawn, 266 plot cycles, x/y scan order 0..18 within each row 0..13; then frame_done pulses.
REQ-031 Pointer at 60 (tile 59 just drawn); set stepMap[3] and stepMap[62] in the same cycle -> tile 62 drawn first, then tile 3.
REQ-032 During DRAW of tile 20, toggle posMap[20] -> tile 20 finishes, then is redrawn once more; frame_done pulses only after the second draw.
REQ-033 full_redraw pulsed in the same cycle SELECT clears dirty[5] -> dirty[5] remains set; all 64 tiles drawn afterwards.
REQ-034 Assert reset at the 100th DRAW cycle of tile 7 -> plot 0 from reset assertion; after release, full 64-tile redraw starting at tile 0.
